// File: rtl/xoodoo_hash_ctrl.sv
// Hash-mode sponge controller driving one Xoodoo permute instance (128-bit rate, 32-bit streams).
// Optional permutation watchdog with perm_err output is enabled by defining XOODOO_CTRL_TIMEOUT_EN.
module xoodoo_hash_ctrl #(
  parameter int unsigned DIGEST_WORDS = 8,
  parameter logic [31:0] DOMAIN       = 32'h00000001,
  parameter int unsigned PERM_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [31:0]   msg_data,
  input  logic          msg_valid,
  input  logic          msg_last,
  output logic          msg_ready,
  output logic [31:0]   dig_data,
  output logic          dig_valid,
  output logic          dig_last,
  input  logic          dig_ready,
  output logic          busy,
  output logic          enable_xoodoo,
  output logic [0:383]  perm_state_in,
  input  logic [0:383]  perm_state_out,
  input  logic          done_permutations
`ifdef XOODOO_CTRL_TIMEOUT_EN
  ,
  output logic          perm_err
`endif
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StAbsorb   = 3'd1;
  localparam logic [2:0] StPad      = 3'd2;
  localparam logic [2:0] StPermReq  = 3'd3;
  localparam logic [2:0] StPermWait = 3'd4;
  localparam logic [2:0] StSqueeze  = 3'd5;

  localparam logic [4:0]  LastDig = 5'(DIGEST_WORDS - 1);
  localparam logic [31:0] PadWord = 32'h00000001;

  logic [2:0]   r_fsm, r_ret;
  logic [0:383] r_state, r_perm_in;
  logic [2:0]   r_widx;
  logic [4:0]   r_dcount;
  logic         r_enable;

  logic [2:0]   w_fsm_d, w_ret_d;
  logic [0:383] w_state_d, w_perm_in_d;
  logic [2:0]   w_widx_d;
  logic [4:0]   w_dcount_d;
  logic         w_enable_d;
  logic [8:0]   w_base;
  logic [31:0]  w_word;

  // Word i of the rate occupies state[32*i : 32*i+31]; bit 32*i is the word's MSB.
  assign w_base = {2'b00, r_widx[1:0], 5'd0};
  assign w_word = r_state[w_base +: 32];

`ifdef XOODOO_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(PERM_TIMEOUT) + 1;

  logic [TW-1:0] r_tcnt, w_tcnt_d;
  logic          r_err, w_err_d;
  logic          w_timeout;

  assign w_timeout = (r_tcnt == TW'(PERM_TIMEOUT - 1));
  assign perm_err  = r_err;
`endif

  always_comb begin
    w_fsm_d     = r_fsm;
    w_ret_d     = r_ret;
    w_state_d   = r_state;
    w_perm_in_d = r_perm_in;
    w_widx_d    = r_widx;
    w_dcount_d  = r_dcount;
    w_enable_d  = 1'b0;
`ifdef XOODOO_CTRL_TIMEOUT_EN
    w_tcnt_d    = r_tcnt;
    w_err_d     = r_err;
`endif
    case (r_fsm)
      StIdle: begin
        if (start) begin
          w_state_d  = '0;
          w_widx_d   = 3'd0;
          w_dcount_d = 5'd0;
          w_fsm_d    = StAbsorb;
`ifdef XOODOO_CTRL_TIMEOUT_EN
          w_err_d    = 1'b0;
`endif
        end
      end
      StAbsorb: begin
        if (msg_valid) begin
          w_state_d[w_base +: 32] = w_word ^ msg_data;
          w_widx_d = r_widx + 3'd1;
          if (msg_last) begin
            w_fsm_d = StPad;
          end else if (r_widx == 3'd3) begin
            w_fsm_d = StPermReq;
            w_ret_d = StAbsorb;
          end
        end
      end
      StPad: begin
        // A full final block pushes the padding into a fresh block after one more permutation.
        if (r_widx[2]) begin
          w_fsm_d = StPermReq;
          w_ret_d = StPad;
        end else begin
          w_state_d[w_base +: 32] = w_word ^ PadWord;
          w_state_d[352:383]      = r_state[352:383] ^ DOMAIN;
          w_fsm_d = StPermReq;
          w_ret_d = StSqueeze;
        end
      end
      StPermReq: begin
        w_perm_in_d = r_state;
        w_enable_d  = 1'b1;
        w_fsm_d     = StPermWait;
`ifdef XOODOO_CTRL_TIMEOUT_EN
        w_tcnt_d    = '0;
`endif
      end
      StPermWait: begin
        if (done_permutations) begin
          w_state_d = perm_state_out;
          w_widx_d  = 3'd0;
          w_fsm_d   = r_ret;
        end
`ifdef XOODOO_CTRL_TIMEOUT_EN
        else if (w_timeout) begin
          w_err_d = 1'b1;
          w_fsm_d = StIdle;
        end else begin
          w_tcnt_d = r_tcnt + 1'b1;
        end
`endif
      end
      StSqueeze: begin
        if (dig_ready) begin
          w_widx_d   = r_widx + 3'd1;
          w_dcount_d = r_dcount + 5'd1;
          if (r_dcount == LastDig) begin
            w_fsm_d = StIdle;
          end else if (r_widx == 3'd3) begin
            w_fsm_d = StPermReq;
            w_ret_d = StSqueeze;
          end
        end
      end
      default: w_fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fsm     <= StIdle;
      r_ret     <= StIdle;
      r_state   <= '0;
      r_perm_in <= '0;
      r_widx    <= 3'd0;
      r_dcount  <= 5'd0;
      r_enable  <= 1'b0;
`ifdef XOODOO_CTRL_TIMEOUT_EN
      r_tcnt    <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_fsm     <= w_fsm_d;
      r_ret     <= w_ret_d;
      r_state   <= w_state_d;
      r_perm_in <= w_perm_in_d;
      r_widx    <= w_widx_d;
      r_dcount  <= w_dcount_d;
      r_enable  <= w_enable_d;
`ifdef XOODOO_CTRL_TIMEOUT_EN
      r_tcnt    <= w_tcnt_d;
      r_err     <= w_err_d;
`endif
    end
  end

  assign msg_ready     = (r_fsm == StAbsorb);
  assign busy          = (r_fsm != StIdle);
  assign dig_valid     = (r_fsm == StSqueeze);
  assign dig_data      = dig_valid ? w_word : 32'd0;
  assign dig_last      = dig_valid && (r_dcount == LastDig);
  assign enable_xoodoo = r_enable;
  assign perm_state_in = r_perm_in;

endmodule

// File: tb/tb_xoodoo_hash_ctrl.sv
// Directed bench for xoodoo_hash_ctrl with a stub permute (identity or zeroing, latency 14).
// The watchdog section is active when XOODOO_CTRL_TIMEOUT_EN is defined.
module tb_xoodoo_hash_ctrl;

  localparam int DW = 8;

  logic         clk = 1'b0;
  logic         resetn, start, msg_valid, msg_last, dig_ready;
  logic         done_permutations = 1'b0;
  logic [31:0]  msg_data, dig_data;
  logic         msg_ready, dig_valid, dig_last, busy, enable_xoodoo;
  logic [0:383] perm_state_in;
  logic [0:383] perm_state_out = '0;
`ifdef XOODOO_CTRL_TIMEOUT_EN
  logic         perm_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xoodoo_hash_ctrl #(
    .DIGEST_WORDS (DW),
    .DOMAIN       (32'h00000001),
    .PERM_TIMEOUT (64)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .msg_data          (msg_data),
    .msg_valid         (msg_valid),
    .msg_last          (msg_last),
    .msg_ready         (msg_ready),
    .dig_data          (dig_data),
    .dig_valid         (dig_valid),
    .dig_last          (dig_last),
    .dig_ready         (dig_ready),
    .busy              (busy),
    .enable_xoodoo     (enable_xoodoo),
    .perm_state_in     (perm_state_in),
    .perm_state_out    (perm_state_out),
    .done_permutations (done_permutations)
`ifdef XOODOO_CTRL_TIMEOUT_EN
    ,
    .perm_err          (perm_err)
`endif
  );

  // Stub permute: captures each request, answers 14 cycles later.
  logic         stub_on   = 1'b1;
  logic         stub_zero = 1'b0;
  logic         stub_chk  = 1'b1;
  int           stub_cnt  = 0;
  int           req_cnt   = 0;
  int           stub_bad  = 0;
  logic [0:383] stub_cap  = '0;
  logic [0:383] req_log [0:15];

  always @(posedge clk) begin
    done_permutations <= 1'b0;
    if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_chk && perm_state_in !== stub_cap) stub_bad <= stub_bad + 1;
      if (stub_cnt == 1) begin
        done_permutations <= 1'b1;
        perm_state_out    <= stub_zero ? '0 : stub_cap;
      end
    end else if (enable_xoodoo === 1'b1 && stub_on) begin
      stub_cap <= perm_state_in;
      if (req_cnt < 16) req_log[req_cnt] <= perm_state_in;
      req_cnt  <= req_cnt + 1;
      stub_cnt <= 14;
    end
  end

  logic [31:0] words [0:DW-1];
  logic        lasts [0:DW-1];

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:383] mk(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3,
                                       input logic [31:0] l11);
    logic [0:383] s;
    s = '0;
    s[0:31]    = w0;
    s[32:63]   = w1;
    s[64:95]   = w2;
    s[96:127]  = w3;
    s[352:383] = l11;
    return s;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    int cyc;
    cyc = 0;
    msg_data = w; msg_valid = 1'b1; msg_last = last;
    while (msg_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("send_ready", msg_ready, 1'b1);
    @(negedge clk);
    msg_valid = 1'b0; msg_last = 1'b0;
  endtask

  task automatic wait_en();
    int cyc;
    cyc = 0;
    while (enable_xoodoo !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("enable_seen", enable_xoodoo, 1'b1);
  endtask

  // Collects DW digest words; optionally stalls dig_ready for 10 cycles at word stall_at.
  task automatic collect(input int stall_at, output int got);
    int          cyc;
    int          stall;
    logic [31:0] held;
    got = 0; cyc = 0; stall = stall_at;
    dig_ready = 1'b1;
    while (got < DW && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (dig_valid === 1'b1) begin
        if (got == stall) begin
          held = dig_data;
          dig_ready = 1'b0;
          repeat (10) begin
            @(negedge clk);
            chk("stall_hold", {dig_valid, dig_data}, {1'b1, held});
          end
          dig_ready = 1'b1;
          stall = -1;
        end
        words[got] = dig_data;
        lasts[got] = dig_last;
        got++;
      end
    end
  endtask

  logic [31:0] exp1 [0:DW-1];
  int          base;
  int          got;
  int          cnt;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp1[0] = 32'hDEADBEEF; exp1[1] = 32'h1; exp1[2] = 32'h0; exp1[3] = 32'h0;
    exp1[4] = 32'hDEADBEEF; exp1[5] = 32'h1; exp1[6] = 32'h0; exp1[7] = 32'h0;
    resetn = 1'b0; start = 1'b0; msg_data = '0; msg_valid = 1'b0; msg_last = 1'b0;
    dig_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_msg_ready", msg_ready, 1'b0);
    chk("rst_dig_valid", dig_valid, 1'b0);
    chk("rst_dig_last", dig_last, 1'b0);
    chk("rst_dig_data", dig_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_enable", enable_xoodoo, 1'b0);
    chk("rst_perm_in", perm_state_in, '0);
`ifdef XOODOO_CTRL_TIMEOUT_EN
    chk("rst_perm_err", perm_err, 1'b0);
`endif
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Single word, identity permute, stall mid-squeeze.
    base = req_cnt;
    do_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_msg_ready", msg_ready, 1'b1);
    send(32'hDEADBEEF, 1'b1);
    collect(2, got);
    chk("t1_count", got, DW);
    for (int i = 0; i < DW; i++) begin
      chk($sformatf("t1_word%0d", i), words[i], exp1[i]);
      chk($sformatf("t1_last%0d", i), lasts[i], (i == DW - 1));
    end
    chk("t1_reqs", req_cnt - base, 2);
    chk("t1_req0", req_log[base], mk(32'hDEADBEEF, 32'h1, 32'h0, 32'h0, 32'h1));
    chk("t1_req1", req_log[base + 1], mk(32'hDEADBEEF, 32'h1, 32'h0, 32'h0, 32'h1));
    repeat (2) @(negedge clk);
    chk("t1_idle", busy, 1'b0);

    // Four-word message, zeroing permute: padding moves to its own block.
    stub_zero = 1'b1;
    base = req_cnt;
    do_start();
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h3, 1'b0);
    send(32'h4, 1'b1);
    collect(-1, got);
    chk("t2_count", got, DW);
    for (int i = 0; i < DW; i++) begin
      chk($sformatf("t2_word%0d", i), words[i], 32'h0);
      chk($sformatf("t2_last%0d", i), lasts[i], (i == DW - 1));
    end
    chk("t2_reqs", req_cnt - base, 3);
    chk("t2_req0", req_log[base], mk(32'h1, 32'h2, 32'h3, 32'h4, 32'h0));
    chk("t2_req1", req_log[base + 1], mk(32'h1, 32'h0, 32'h0, 32'h0, 32'h1));
    chk("t2_req2", req_log[base + 2], mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    repeat (2) @(negedge clk);
    stub_zero = 1'b0;

    // Start pulse while waiting on the permutation is ignored.
    base = req_cnt;
    do_start();
    send(32'hDEADBEEF, 1'b1);
    wait_en();
    repeat (3) @(negedge clk);
    do_start();
    chk("t3_busy", busy, 1'b1);
    collect(-1, got);
    chk("t3_count", got, DW);
    for (int i = 0; i < DW; i++) begin
      chk($sformatf("t3_word%0d", i), words[i], exp1[i]);
    end
    chk("t3_reqs", req_cnt - base, 2);
    repeat (2) @(negedge clk);

    // Reset during PERM_WAIT; the late done pulse must be ignored.
    stub_chk = 1'b0;
    base = req_cnt;
    do_start();
    send(32'hDEADBEEF, 1'b1);
    wait_en();
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_msg_ready", msg_ready, 1'b0);
    chk("t4_dig_valid", dig_valid, 1'b0);
    chk("t4_dig_data", dig_data, 32'd0);
    chk("t4_enable", enable_xoodoo, 1'b0);
    chk("t4_perm_in", perm_state_in, '0);
    repeat (20) @(negedge clk);
    chk("t4_busy_late", busy, 1'b0);
    chk("t4_dig_valid_late", dig_valid, 1'b0);
    chk("t4_dig_last_late", dig_last, 1'b0);
    chk("t4_perm_in_late", perm_state_in, '0);
    chk("t4_reqs", req_cnt - base, 1);
    stub_chk = 1'b1;
    chk("stub_stable", stub_bad, 0);

`ifdef XOODOO_CTRL_TIMEOUT_EN
    // Permute never answers: watchdog fires 64 cycles after the request.
    stub_on = 1'b0;
    do_start();
    send(32'hDEADBEEF, 1'b1);
    wait_en();
    cnt = 0;
    while (perm_err !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_cycles", cnt, 64);
    chk("to_busy", busy, 1'b0);
    chk("to_err", perm_err, 1'b1);
    do_start();
    chk("to_err_cleared", perm_err, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    stub_on = 1'b1;
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
